divider: RTL and testbench

//  Sequential restoring unsigned divider, WIDTH-bit dividend / WIDTH-bit divisor.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 19 +
 rtl/divider.sv | 121 ++++++++++++
 tb/tb_divider.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  assign trial = {r_in, q_msb} - {1'b0, d};
  assign q_bit = ~trial[WIDTH];
  // When the trial goes negative the shifted value is below d, so its top bit is zero.
  assign r_out = q_bit ? trial[WIDTH-1:0] : {r_in[WIDTH-2:0], q_msb};

endmodule

// File: rtl/divider.sv
// Sequential restoring unsigned divider with start/done handshake and divide-by-zero flag.
module divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             start_prev_q;
  logic [WIDTH-1:0] q_sh_q, q_sh_d;
  logic [WIDTH-1:0] d_q, d_d;
  // Partial remainder always stays below the divisor, so WIDTH bits suffice.
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_r;
  logic             step_bit;
  logic [WIDTH-1:0] q_next;
  logic             launch;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_msb (q_sh_q[WIDTH-1]),
    .d     (d_q),
    .r_out (step_r),
    .q_bit (step_bit)
  );

  assign q_next = {q_sh_q[WIDTH-2:0], step_bit};
  assign launch = (state_q == S_IDLE) && start && !start_prev_q;

  always_comb begin
    state_d = state_q;
    q_sh_d  = q_sh_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          q_sh_d = ain;
          d_d    = bin;
          r_d    = '0;
          cnt_d  = '0;
          if (bin == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = ain;
            dz_d    = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        q_sh_d = q_next;
        r_d    = step_r;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          quo_d   = q_next;
          rem_d   = step_r;
          dz_d    = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      q_sh_q       <= '0;
      d_q          <= '0;
      r_q          <= '0;
      cnt_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      dz_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start;
      q_sh_q       <= q_sh_d;
      d_q          <= d_d;
      r_q          <= r_d;
      cnt_q        <= cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      dz_q         <= dz_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign busy      = (state_q == S_CALC);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_divider.sv
// Directed and random checks of the divider: latency, handshake, boundaries, reset abort.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] ain, bin;
  logic [15:0] quotient, remainder;
  logic        div_zero, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  divider #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ain       (ain),
    .bin       (bin),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .busy      (busy),
    .done      (done)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_single", {31'd0, done_prev}, 32'd0);
    end
    done_prev = done;
  end

  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input bit tog, input string tag);
    int i;
    int busy_n;
    int dc0;
    @(negedge clk);
    ain   = a;
    bin   = b;
    start = 1'b1;
    dc0   = done_cnt;
    @(posedge clk); #1;
    i      = 1;
    busy_n = 0;
    while (!done && i < 40) begin
      if (busy) busy_n++;
      if (tog && b != 0 && (i == 5 || i == 6)) begin
        @(negedge clk);
        start = (i == 6);
        ain   = ~a;
        bin   = ~b;
      end
      @(posedge clk); #1;
      i++;
    end
    check({tag, "_lat"},  i, (b == 0) ? 1 : 17);
    check({tag, "_busyn"}, busy_n, (b == 0) ? 0 : 16);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_q"},    {16'd0, quotient}, {16'd0, eq});
    check({tag, "_r"},    {16'd0, remainder}, {16'd0, er});
    check({tag, "_dz"},   {31'd0, div_zero}, {31'd0, edz});
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_ndone"}, done_cnt - dc0, 1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dc0;
    logic [15:0] a, b;
    int sel;
    rst   = 1'b1;
    start = 1'b0;
    ain   = '0;
    bin   = '0;
    repeat (50) @(posedge clk);
    #1;
    check("rst_q",    {16'd0, quotient}, 0);
    check("rst_r",    {16'd0, remainder}, 0);
    check("rst_dz",   {31'd0, div_zero}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_div(16'd2937,  16'd33,    16'd89,    16'd0,   1'b0, 1'b0, "t1");
    do_div(16'd65535, 16'd1,     16'd65535, 16'd0,   1'b0, 1'b0, "t2a");
    do_div(16'd5,     16'd7,     16'd0,     16'd5,   1'b0, 1'b0, "t2b");
    do_div(16'd65535, 16'd65535, 16'd1,     16'd0,   1'b0, 1'b0, "t2c");
    do_div(16'd0,     16'd9,     16'd0,     16'd0,   1'b0, 1'b0, "t2d");
    do_div(16'd100,   16'd0,     16'hFFFF,  16'd100, 1'b1, 1'b0, "t3a");
    do_div(16'd100,   16'd7,     16'd14,    16'd2,   1'b0, 1'b0, "t3b");
    do_div(16'd4660,  16'd4660,  16'd1,     16'd0,   1'b0, 1'b1, "t2e");

    // start held high: one operation only, result held afterwards
    @(negedge clk);
    ain   = 16'd2937;
    bin   = 16'd33;
    start = 1'b1;
    dc0   = done_cnt;
    repeat (225) @(negedge clk);
    check("t4_ndone", done_cnt - dc0, 1);
    check("t4_q", {16'd0, quotient}, 89);
    check("t4_r", {16'd0, remainder}, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-operation abandons the divide
    ain   = 16'd1000;
    bin   = 16'd3;
    start = 1'b1;
    dc0   = done_cnt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_busy_pre", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_ndone", done_cnt - dc0, 0);
    check("t5_q",     {16'd0, quotient}, 0);
    check("t5_r",     {16'd0, remainder}, 0);
    check("t5_dz",    {31'd0, div_zero}, 0);
    check("t5_busy",  {31'd0, busy}, 0);
    do_div(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, "t5b");

    for (int n = 0; n < 1000; n++) begin
      a   = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 16'd0;
      else if (sel < 4)  b = 16'($urandom_range(1, 15));
      else if (sel == 4) b = a;
      else               b = 16'($urandom);
      if (b == 16'd0)
        do_div(a, b, 16'hFFFF, a, 1'b1, 1'b0, "rnd");
      else
        do_div(a, b, a / b, a % b, 1'b0, ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
